hilo_muldiv_unit: RTL

Parametrised HI/LO unit: it holds the HI and LO registers and contains a multi-cycle multiply/divide engine. It is the successor of the plain HI/LO register pair. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the EX stage, and raises busy/stall so the hazard unit can hold MFHI/MFLO and further mul/div ops. HI/LO read values feed the ID stage.

---
 rtl/hilo_muldiv_unit.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
//
// Holds the HI and LO registers and contains a multi-cycle multiply/divide
// engine. MTHI/MTLO write immediately. MULT/MULTU/DIV/DIVU run in the RUN
// state and write {HI,LO} on their final edge. While an operation runs, busy
// is high so the hazard unit can hold dependent instructions.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst     - asynchronous, active-high reset
//   start   - issue the operation on op this cycle
//   op      - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 NOP
//   a, b    - rs / rt operands, captured when the operation is accepted
//   flush   - abort the running operation and drop this cycle's start
//   busy    - multiply/divide in progress
//   stall   - start && busy (combinational)
//   done    - one-cycle pulse after a multiply/divide result is written
//   hiout   - current HI register
//   loout   - current LO register
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hiout,
    output logic [WIDTH-1:0] loout
);

    typedef enum logic {IDLE, RUN} state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    // The counter holds cycles remaining before the write edge.
    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_sor;
    logic             neg_quo;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    op_t              op_sel;
    logic             accept;
    logic             sdiv;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign busy  = (state == RUN);
    assign stall = start && busy;
    assign done  = done_q;
    assign hiout = hi_q;
    assign loout = lo_q;

    assign op_sel = op_t'(op);
    assign accept = start && !busy && !flush && (op < 3'd6);

    // Signed division runs unsigned on magnitudes, signs are reapplied at the end.
    assign sdiv  = (op_sel == OP_DIV);
    assign a_neg = sdiv && a[WIDTH-1];
    assign b_neg = sdiv && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // NOTE: every signal assigned in an always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        ext_a   = {{WIDTH{1'b0}}, op_a};
        ext_b   = {{WIDTH{1'b0}}, op_b};
        if (is_signed) begin
            ext_a = {{WIDTH{op_a[WIDTH-1]}}, op_a};
            ext_b = {{WIDTH{op_b[WIDTH-1]}}, op_b};
        end
        // The low 2*WIDTH bits of the extended product are correct for both
        // signed and unsigned operands.
        product = ext_a * ext_b;
    end

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, div_sor};
        rem_n   = shifted[WIDTH-1:0];
        quo_n   = {quo_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_n = trial[WIDTH-1:0];
            quo_n = {quo_q[WIDTH-2:0], 1'b1};
        end
        // Most-negative / -1 yields magnitude 2^(WIDTH-1), whose negation is
        // itself, so no special case is needed.
        quo_fix = neg_quo ? -quo_n : quo_n;
        rem_fix = neg_rem ? -rem_n : rem_n;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_sor   <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op_sel)
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            OP_MULT, OP_MULTU: begin
                                state     <= RUN;
                                cnt       <= CW'(MUL_CYCLES - 1);
                                is_div    <= 1'b0;
                                is_signed <= (op_sel == OP_MULT);
                                op_a      <= a;
                                op_b      <= b;
                            end
                            default: begin // DIV, DIVU
                                state    <= RUN;
                                cnt      <= CW'(WIDTH - 1);
                                is_div   <= 1'b1;
                                op_a     <= a;
                                rem_q    <= '0;
                                quo_q    <= a_mag;
                                div_sor  <= b_mag;
                                neg_quo  <= a_neg ^ b_neg;
                                neg_rem  <= a_neg;
                                div_zero <= (b == '0);
                            end
                        endcase
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        // The last division step is folded into the write edge.
                        state  <= IDLE;
                        done_q <= 1'b1;
                        if (!is_div) begin
                            hi_q <= product[2*WIDTH-1:WIDTH];
                            lo_q <= product[WIDTH-1:0];
                        end else if (div_zero) begin
                            hi_q <= op_a;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (is_div) begin
                            rem_q <= rem_n;
                            quo_q <= quo_n;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
